// File: rtl/register_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: register tag and data word
// types plus the index of the hardwired-zero register.
package register_scoreboard_pkg;

  localparam int TAG_W    = 5;
  localparam int WORD_W   = 32;
  localparam int NUM_REGS = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam tag_t REG_ZERO = '0;

endpackage

// File: rtl/scoreboard_counter.sv
// Per-register pending-write counter: saturating up/down with clear priority
// and detection of a decrement attempted at zero.
module scoreboard_counter #(
  parameter int MAX_COUNT = 3,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_ok;

  assign dec_ok      = dec_i && (cnt_q != '0);
  assign underflow_o = dec_i && (cnt_q == '0);
  assign cnt_o       = cnt_q;

  // A decrement at zero is dropped, so a simultaneous increment still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_ok && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_ok && !inc_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard gating issue into the pipeline: blocks RAW hazards
// and over-deep WAW chains, and tracks total in-flight writes and stall cycles.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  input  tag_t                   issue_rs1,
  input  tag_t                   issue_rs2,
  input  logic                   issue_uses_rs1,
  input  logic                   issue_uses_rs2,
  input  tag_t                   issue_rd,
  input  logic                   issue_writes_rd,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  tag_t                   wb_rd,
  input  logic                   flush,
  output logic [7:0]             inflight_total,
  output logic                   underflow_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int               CNT_W    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] under_vec;

  logic hazard_rs1, hazard_rs2, full_rd;
  logic fire, fire_w, wb_under, wb_dec;

  logic [7:0]             total_q, total_d;
  logic                   under_q, under_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign cnt[0]       = '0;
  assign under_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    scoreboard_counter #(
      .MAX_COUNT (MAX_INFLIGHT),
      .CNT_W     (CNT_W)
    ) u_cnt (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .clear_i     (flush),
      .inc_i       (fire_w && (issue_rd == tag_t'(r))),
      .dec_i       (wb_valid && (wb_rd == tag_t'(r))),
      .cnt_o       (cnt[r]),
      .underflow_o (under_vec[r])
    );
  end

  // Counters are read before this cycle's writeback: no same-cycle bypass.
  always_comb begin
    hazard_rs1  = issue_uses_rs1 && (issue_rs1 != REG_ZERO) && (cnt[issue_rs1] != '0);
    hazard_rs2  = issue_uses_rs2 && (issue_rs2 != REG_ZERO) && (cnt[issue_rs2] != '0);
    full_rd     = issue_writes_rd && (issue_rd != REG_ZERO) && (cnt[issue_rd] == CNT_FULL);
    issue_ready = !(hazard_rs1 || hazard_rs2 || full_rd);
    fire        = issue_valid && issue_ready;
    fire_w      = fire && issue_writes_rd && (issue_rd != REG_ZERO);
    wb_under    = |under_vec;
    wb_dec      = wb_valid && (wb_rd != REG_ZERO) && !wb_under;
  end

  always_comb begin
    total_d = flush ? '0 : (total_q + {7'd0, fire_w} - {7'd0, wb_dec});
    under_d = under_q | wb_under;
    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total_q <= '0;
      under_q <= 1'b0;
      stall_q <= '0;
    end else begin
      total_q <= total_d;
      under_q <= under_d;
      stall_q <= stall_d;
    end
  end

  assign inflight_total  = total_q;
  assign underflow_error = under_q;
  assign stall_cycles    = stall_q;

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Per-register pending-write tracker that gates instruction issue into the 7-stage pipeline so no instruction reads a register file entry with a write still in flight.
- Sits between decode and register read; fed by the writeback stage's register_writeback/rd.
- Tracks up to MAX_INFLIGHT outstanding writes per architectural register.
- Supports pipeline flush and exposes a sticky protocol-error flag and a stall-cycle counter.

Parameters:
MAX_INFLIGHT, 3, max outstanding writes per register; per-register counter width = $clog2(MAX_INFLIGHT+1)
STALL_CNT_W, 32, width of the stall-cycle performance counter

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode presents an instruction
issue_rs1  input  tag  source register 1
issue_rs2  input  tag  source register 2
issue_uses_rs1  input  1  instruction reads rs1
issue_uses_rs2  input  1  instruction reads rs2
issue_rd  input  tag  destination register
issue_writes_rd  input  1  instruction writes rd
issue_ready  output  1  no hazard; combinational from inputs and counter state
wb_valid  input  1  writeback stage commits a register write (register_writeback)
wb_rd  input  tag  destination being written back
flush  input  1  discard all in-flight instructions
inflight_total  output  8  sum of all per-register counters, registered
underflow_error  output  1  sticky: writeback to a register with count 0
stall_cycles  output  STALL_CNT_W  saturating count of issue_valid && !issue_ready cycles

Behaviour:
- Clock/reset: one clock (clock); reset_n asynchronous active-low, fixed.
- Reset: all counters 0, inflight_total 0, underflow_error 0, stall_cycles 0; issue_ready then depends only on issue_* inputs and is 1 for any instruction.
- x0 is never tracked: rs/rd == 0 never causes a hazard, never increments or decrements.
- hazard_rs1 = issue_uses_rs1 && rs1 != 0 && cnt[rs1] != 0; hazard_rs2 likewise.
- full_rd = issue_writes_rd && rd != 0 && cnt[rd] == MAX_INFLIGHT.
- issue_ready = !(hazard_rs1 || hazard_rs2 || full_rd).
- issue_ready does not depend on issue_valid.
- fire = issue_valid && issue_ready.
- No same-cycle writeback bypass: the register file captures read data and applies the write on the same edge, and the read sees the old value. A hazard therefore persists in the cycle wb_valid retires the last pending write and clears on the following cycle.
- Counter update per register r != 0, at the clock edge:
  - +1 if fire && writes_rd && rd == r
  - -1 if wb_valid && wb_rd == r && cnt[r] != 0
  - Both in the same cycle: net unchanged.
- WAW is permitted up to MAX_INFLIGHT, since writeback is in order.
- Underflow: wb_valid with wb_rd != 0 and cnt[wb_rd] == 0 sets underflow_error. Counters stay at 0, no wrap. The flag clears only on reset.
- Flush: has priority over issue and wb in the same cycle. Next edge, all counters and inflight_total are 0. underflow_error and stall_cycles are unaffected. issue_ready still evaluates combinationally in the flush cycle, but a fire in that cycle is discarded.
- inflight_total: registered next-state sum, maintained incrementally (+fire_w, -wb_dec) rather than recomputed.
- stall_cycles: +1 each cycle issue_valid && !issue_ready, saturating at all-ones. Not cleared by flush.
- Reset asserted mid-operation: all state clears immediately (asynchronous); no pending writes survive.

Decomposition:
- Shared definitions package: tag (5-bit), word (32-bit), and the register-index constant REG_ZERO = 0.
- MAX_INFLIGHT stays a local parameter.
- One natural sub-module, scoreboard_counter: saturating up/down counter with inc, dec, clear and underflow-detect. Instantiated 31 times (x1..x31) via generate.
- Hazard compare and total-sum logic stay in the top level.

Test Plan:
- Reset then issue rd=5, uses none -> issue_ready=1, cnt[5]=1, inflight_total=1. Next instruction with rs1=5 -> issue_ready=0, stall_cycles increments each cycle.
- wb_valid wb_rd=5 while rs1=5 instruction waits -> issue_ready stays 0 that cycle, becomes 1 the next cycle; cnt[5]=0.
- Issue rd=7 three times (MAX_INFLIGHT=3) -> fourth issue writing rd=7 gets issue_ready=0. Simultaneous issue rd=7 and wb_rd=7 with cnt=3 -> still blocked, since the full check precedes the decrement. With cnt=2 -> fires, cnt stays 2.
- rs1=0, rd=0 with all counters 0 -> ready=1, no state change. wb_valid wb_rd=0 -> no underflow.
- wb_valid wb_rd=9 with cnt[9]=0 -> underflow_error=1, stays 1 after flush, cleared by reset_n low.
- cnt[3]=2, cnt[4]=1, then flush with simultaneous issue rd=3 and wb rd=4 -> next cycle all counters 0, inflight_total=0. reset_n asserted asynchronously mid-cycle -> outputs clear before the next edge.
